// File: rtl/wb_commit_pkg.sv
// Shared widths, the MEM->WB bundle type and the stage-update decode for the writeback commit block.
package wb_commit_pkg;

    localparam int REG_ADDR_W = 5;
    localparam int REG_W      = 32;

    localparam logic [REG_W-1:0]      ZERO_WORD     = '0;
    localparam logic [REG_ADDR_W-1:0] NOP_REG_ADDR  = '0;
    localparam logic                  WRITE_ENABLE  = 1'b1;
    localparam logic                  WRITE_DISABLE = 1'b0;

    // Everything MEM hands to WB in one cycle.
    typedef struct packed {
        logic [REG_ADDR_W-1:0] wd;
        logic                  wreg;
        logic [REG_W-1:0]      wdata;
        logic [REG_W-1:0]      hi;
        logic [REG_W-1:0]      lo;
        logic                  whilo;
    } wb_bundle_t;

    // A bubble is the all-zero bundle: no GPR write, no HI/LO write, and it never retires.
    // It is loaded on a flush, and whenever MEM is held while WB drains, so that the
    // held MEM instruction is not committed twice.
    localparam wb_bundle_t WB_BUBBLE = '{
        wd:    NOP_REG_ADDR,
        wreg:  WRITE_DISABLE,
        wdata: ZERO_WORD,
        hi:    ZERO_WORD,
        lo:    ZERO_WORD,
        whilo: WRITE_DISABLE
    };

    typedef enum logic [1:0] {
        STAGE_BUBBLE,
        STAGE_CAPTURE,
        STAGE_HOLD
    } stage_op_t;

    // Resolve the stage-register action. Flush outranks any stall combination.
    function automatic stage_op_t decode_stage_op(input logic flush,
                                                  input logic stall_mem,
                                                  input logic stall_wb);
        if (flush)                    return STAGE_BUBBLE;
        else if (stall_mem && !stall_wb) return STAGE_BUBBLE;
        else if (!stall_mem)          return STAGE_CAPTURE;
        else                          return STAGE_HOLD;
    endfunction

endpackage

// File: rtl/wb_commit_hilo_reg.sv
// Architectural HI/LO register pair, written together when we is high.
module hilo_reg
    import wb_commit_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             we,
    input  logic [REG_W-1:0] hi_i,
    input  logic [REG_W-1:0] lo_i,
    output logic [REG_W-1:0] hi_o,
    output logic [REG_W-1:0] lo_o
);

    // HI/LO update on commit; cleared by the active-low reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            hi_o <= ZERO_WORD;
            lo_o <= ZERO_WORD;
        end else if (we) begin
            // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
            hi_o <= hi_i;
            lo_o <= lo_i;
        end
    end

endmodule

// File: rtl/wb_commit.sv
// MEM/WB pipeline register, HI/LO commit with EX-side bypass, and retired-write counter.
module wb_commit
    import wb_commit_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  stall_mem,
    input  logic                  stall_wb,
    input  logic                  flush,
    input  logic [REG_ADDR_W-1:0] wd_i,
    input  logic                  wreg_i,
    input  logic [REG_W-1:0]      wdata_i,
    input  logic [REG_W-1:0]      hi_i,
    input  logic [REG_W-1:0]      lo_i,
    input  logic                  whilo_i,
    output logic [REG_ADDR_W-1:0] wb_wd_o,
    output logic                  wb_wreg_o,
    output logic [REG_W-1:0]      wb_wdata_o,
    output logic [REG_W-1:0]      hi_o,
    output logic [REG_W-1:0]      lo_o,
    output logic [REG_W-1:0]      retired_o
);

    wb_bundle_t       stage_q;
    wb_bundle_t       stage_d;
    wb_bundle_t       mem_in;
    logic             commit;
    logic [REG_W-1:0] hi_arch;
    logic [REG_W-1:0] lo_arch;
    logic [REG_W-1:0] retire_q;

    assign mem_in = '{
        wd:    wd_i,
        wreg:  wreg_i,
        wdata: wdata_i,
        hi:    hi_i,
        lo:    lo_i,
        whilo: whilo_i
    };

    // Next stage-register contents: bubble, capture from MEM, or hold.
    always_comb begin
        // NOTE: default assigned first so no path through this block can infer a latch.
        stage_d = stage_q;
        unique case (decode_stage_op(flush, stall_mem, stall_wb))
            STAGE_BUBBLE:  stage_d = WB_BUBBLE;
            STAGE_CAPTURE: stage_d = mem_in;
            STAGE_HOLD:    stage_d = stage_q;
            default:       stage_d = WB_BUBBLE;
        endcase
    end

    // MEM/WB stage register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) stage_q <= WB_BUBBLE;
        else      stage_q <= stage_d;
    end

    // The instruction in WB commits at the edge where WB is not held.
    assign commit = !stall_wb;

    hilo_reg u_hilo (
        .clk  (clk),
        .rst  (rst),
        .we   (commit && stage_q.whilo),
        .hi_i (stage_q.hi),
        .lo_i (stage_q.lo),
        .hi_o (hi_arch),
        .lo_o (lo_arch)
    );

    // Count every committed GPR or HI/LO write; wraps silently.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)                                      retire_q <= ZERO_WORD;
        else if (commit && (stage_q.wreg || stage_q.whilo)) retire_q <= retire_q + 1'b1;
    end

    assign wb_wd_o    = stage_q.wd;
    assign wb_wreg_o  = stage_q.wreg;
    assign wb_wdata_o = stage_q.wdata;
    // EX sees a pending WB-stage HI/LO write before it reaches the architectural pair.
    assign hi_o       = stage_q.whilo ? stage_q.hi : hi_arch;
    assign lo_o       = stage_q.whilo ? stage_q.lo : lo_arch;
    assign retired_o  = retire_q;

endmodule

// File: tb/tb_wb_commit.sv
// Directed self-checking bench for wb_commit.
module tb_wb_commit;
    import wb_commit_pkg::*;

    logic                  clk = 1'b0;
    logic                  rst;
    logic                  stall_mem, stall_wb, flush;
    logic [REG_ADDR_W-1:0] wd_i;
    logic                  wreg_i, whilo_i;
    logic [REG_W-1:0]      wdata_i, hi_i, lo_i;
    logic [REG_ADDR_W-1:0] wb_wd_o;
    logic                  wb_wreg_o;
    logic [REG_W-1:0]      wb_wdata_o, hi_o, lo_o, retired_o;

    int checks = 0;
    int errors = 0;

    wb_commit dut (
        .clk        (clk),
        .rst        (rst),
        .stall_mem  (stall_mem),
        .stall_wb   (stall_wb),
        .flush      (flush),
        .wd_i       (wd_i),
        .wreg_i     (wreg_i),
        .wdata_i    (wdata_i),
        .hi_i       (hi_i),
        .lo_i       (lo_i),
        .whilo_i    (whilo_i),
        .wb_wd_o    (wb_wd_o),
        .wb_wreg_o  (wb_wreg_o),
        .wb_wdata_o (wb_wdata_o),
        .hi_o       (hi_o),
        .lo_o       (lo_o),
        .retired_o  (retired_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, observed, expected);
        end
    endtask

    // Advance one rising edge and settle 1 time unit past it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [4:0] wd, input logic wreg, input logic [31:0] wdata,
                         input logic whilo, input logic [31:0] hi, input logic [31:0] lo);
        wd_i = wd; wreg_i = wreg; wdata_i = wdata; whilo_i = whilo; hi_i = hi; lo_i = lo;
    endtask

    task automatic ctrl(input logic f, input logic sm, input logic sw);
        flush = f; stall_mem = sm; stall_wb = sw;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_wd"},    32'(wb_wd_o),   32'h0);
        check({tag, "_wreg"},  32'(wb_wreg_o), 32'h0);
        check({tag, "_wdata"}, wb_wdata_o,     32'h0);
        check({tag, "_hi"},    hi_o,           32'h0);
        check({tag, "_lo"},    lo_o,           32'h0);
        check({tag, "_ret"},   retired_o,      32'h0);
    endtask

    initial begin
        rst = 1'b0;
        ctrl(1'b0, 1'b0, 1'b0);
        drive(5'd0, 1'b0, 32'h0, 1'b0, 32'h0, 32'h0);
        step();
        step();
        rst = 1'b1;
        check_all_zero("reset_init");

        // T2 passthrough
        drive(5'd3, 1'b1, 32'hDEADBEEF, 1'b0, 32'h0, 32'h0);
        step();
        check("t2_wd",    32'(wb_wd_o),   32'd3);
        check("t2_wreg",  32'(wb_wreg_o), 32'd1);
        check("t2_wdata", wb_wdata_o,     32'hDEADBEEF);
        check("t2_ret_pending", retired_o, 32'd0);
        drive(5'd0, 1'b0, 32'h0, 1'b0, 32'h0, 32'h0);
        step();
        check("t2_ret",       retired_o,      32'd1);
        check("t2_wreg_drop", 32'(wb_wreg_o), 32'd0);

        // T3 HI/LO bypass then commit
        drive(5'd0, 1'b0, 32'h0, 1'b1, 32'h1, 32'h2);
        step();
        check("t3_hi_bypass", hi_o, 32'h1);
        check("t3_lo_bypass", lo_o, 32'h2);
        check("t3_arch_hi_old", dut.hi_arch, 32'h0);
        drive(5'd0, 1'b0, 32'h0, 1'b0, 32'h0, 32'h0);
        step();
        check("t3_hi_commit", hi_o, 32'h1);
        check("t3_lo_commit", lo_o, 32'h2);
        check("t3_ret", retired_o, 32'd2);

        // T4a MEM held, WB drains: bubble
        ctrl(1'b0, 1'b1, 1'b0);
        drive(5'd7, 1'b1, 32'h55, 1'b0, 32'h0, 32'h0);
        step();
        check("t4_bubble_wreg", 32'(wb_wreg_o), 32'd0);
        check("t4_bubble_wd",   32'(wb_wd_o),   32'd0);
        check("t4_bubble_ret",  retired_o,      32'd2);

        // T4b capture, then hold with both stalled for 3 cycles
        ctrl(1'b0, 1'b0, 1'b0);
        drive(5'd9, 1'b1, 32'h77, 1'b1, 32'hAAAA, 32'hBBBB);
        step();
        check("t4_cap_wd", 32'(wb_wd_o), 32'd9);
        check("t4_cap_hi", hi_o, 32'hAAAA);
        check("t4_cap_ret", retired_o, 32'd2);
        ctrl(1'b0, 1'b1, 1'b1);
        drive(5'd1, 1'b0, 32'h0, 1'b0, 32'h0, 32'h0);
        for (int i = 0; i < 3; i++) begin
            step();
            check("t4_hold_wd",    32'(wb_wd_o),   32'd9);
            check("t4_hold_wreg",  32'(wb_wreg_o), 32'd1);
            check("t4_hold_wdata", wb_wdata_o,     32'h77);
            check("t4_hold_hi",    hi_o,           32'hAAAA);
            check("t4_hold_lo",    lo_o,           32'hBBBB);
            check("t4_hold_arch",  dut.hi_arch,    32'h1);
            check("t4_hold_ret",   retired_o,      32'd2);
        end
        ctrl(1'b0, 1'b0, 1'b0);
        step();
        check("t4_drain_ret",  retired_o,      32'd3);
        check("t4_drain_wreg", 32'(wb_wreg_o), 32'd0);
        check("t4_drain_hi",   hi_o,           32'hAAAA);
        check("t4_drain_lo",   lo_o,           32'hBBBB);

        // T5 flush wins over both stalls
        ctrl(1'b1, 1'b1, 1'b1);
        drive(5'd6, 1'b1, 32'h99, 1'b1, 32'hCCCC, 32'hDDDD);
        step();
        check("t5_wreg", 32'(wb_wreg_o), 32'd0);
        check("t5_hi",   hi_o,           32'hAAAA);
        check("t5_lo",   lo_o,           32'hBBBB);
        check("t5_ret",  retired_o,      32'd3);
        ctrl(1'b0, 1'b0, 1'b0);
        drive(5'd0, 1'b0, 32'h0, 1'b0, 32'h0, 32'h0);
        step();
        check("t5_hi_after", hi_o,      32'hAAAA);
        check("t5_ret_after", retired_o, 32'd3);

        // T1 async reset mid-stall, no clock edge
        drive(5'd5, 1'b1, 32'h1234, 1'b1, 32'h11, 32'h22);
        step();
        check("t1_pre_wreg", 32'(wb_wreg_o), 32'd1);
        ctrl(1'b0, 1'b1, 1'b1);
        step();
        #2;
        rst = 1'b0;
        #1;
        check_all_zero("t1_async");
        ctrl(1'b0, 1'b0, 1'b0);
        drive(5'd0, 1'b0, 32'h0, 1'b0, 32'h0, 32'h0);
        step();
        rst = 1'b1;
        step();
        check_all_zero("t1_release");

        // T6 counter wrap
        drive(5'd4, 1'b1, 32'h4, 1'b0, 32'h0, 32'h0);
        step();
        force dut.retire_q = 32'hFFFFFFFF;
        #1;
        release dut.retire_q;
        #1;
        check("t6_preset", retired_o, 32'hFFFFFFFF);
        drive(5'd0, 1'b0, 32'h0, 1'b0, 32'h0, 32'h0);
        step();
        check("t6_wrap", retired_o, 32'h0);
        step();
        check("t6_after_bubble", retired_o, 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    // Guard against a hung run.
    initial begin
        #100000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
